// File: rtl/hazard_ctrl_unit.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stall/flush
// generation, MUL/DIV occupancy FSM and a saturating stall counter.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LAT     = 4,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcodeD,
    input  logic [5:0]            funcD,
    input  logic [REG_ADDR_W-1:0] rsD,
    input  logic [REG_ADDR_W-1:0] rtD,
    input  logic [REG_ADDR_W-1:0] writeRegE,
    input  logic                  regWriteE,
    input  logic                  memToRegE,
    input  logic [REG_ADDR_W-1:0] writeRegM,
    input  logic                  memToRegM,
    input  logic                  branchTakenD,
    input  logic                  jumpD,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  mdStart,
    output logic                  mdBusy,
    output logic [CNT_W-1:0]      stallCount
);

    localparam int MDC_W = $clog2(MD_LAT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic SQUASH_D = (DELAY_SLOT == 0);

    logic [0:0]       state_q, state_d;
    logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_busy_q, md_busy_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic is_branch, is_md, is_mf;
    logic e_hits_src, m_hits_src;
    logic lu_haz, br_haz, md_haz;
    logic stall_raw, stall, start;

    always_comb begin
        is_branch  = (opcodeD == 6'h04) || (opcodeD == 6'h05);
        is_md      = (opcodeD == 6'h00) && (funcD[5:2] == 4'b0110);
        is_mf      = (opcodeD == 6'h00) && ((funcD == 6'h10) || (funcD == 6'h12));

        // Register 0 is hard-wired, so a write to it never creates a dependency.
        e_hits_src = (writeRegE != '0) && ((writeRegE == rsD) || (writeRegE == rtD));
        m_hits_src = (writeRegM != '0) && ((writeRegM == rsD) || (writeRegM == rtD));

        lu_haz     = memToRegE && regWriteE && e_hits_src;
        br_haz     = is_branch && ((regWriteE && e_hits_src) || (memToRegM && m_hits_src));
        md_haz     = (state_q == ST_BUSY) && (is_md || is_mf);

        stall_raw  = lu_haz || br_haz || md_haz;
        stall      = stall_raw && !rst;
        start      = !rst && (state_q == ST_IDLE) && is_md && !stall_raw;
    end

    always_comb begin
        stallF  = stall;
        stallD  = stall;
        flushE  = stall;
        flushD  = SQUASH_D && !rst && (branchTakenD || jumpD) && !stall_raw;
        mdStart = start;
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_BUSY;
                    md_cnt_d = MDC_W'(MD_LAT - 1);
                end
            end
            ST_BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    md_cnt_d = md_cnt_q - MDC_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                md_cnt_d = '0;
            end
        endcase
        md_busy_d = (state_d == ST_BUSY);
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            md_cnt_q      <= '0;
            md_busy_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            md_busy_q     <= md_busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mdBusy     = md_busy_q;
    assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (squashing/MD_LAT=4/16-bit count and
// delay-slot/MD_LAT=1/4-bit count) driven by shared inputs, checked against a cycle model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcodeD, funcD;
    logic [4:0] rsD, rtD, writeRegE, writeRegM;
    logic       regWriteE, memToRegE, memToRegM, branchTakenD, jumpD;

    logic        stallF0, stallD0, flushD0, flushE0, mdStart0, mdBusy0;
    logic [15:0] stallCount0;
    logic        stallF1, stallD1, flushD1, flushE1, mdStart1, mdBusy1;
    logic [3:0]  stallCount1;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .MD_LAT(4), .DELAY_SLOT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .opcodeD(opcodeD), .funcD(funcD), .rsD(rsD), .rtD(rtD),
        .writeRegE(writeRegE), .regWriteE(regWriteE), .memToRegE(memToRegE),
        .writeRegM(writeRegM), .memToRegM(memToRegM), .branchTakenD(branchTakenD),
        .jumpD(jumpD), .stallF(stallF0), .stallD(stallD0), .flushD(flushD0),
        .flushE(flushE0), .mdStart(mdStart0), .mdBusy(mdBusy0), .stallCount(stallCount0));

    hazard_ctrl_unit #(.REG_ADDR_W(5), .MD_LAT(1), .DELAY_SLOT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .opcodeD(opcodeD), .funcD(funcD), .rsD(rsD), .rtD(rtD),
        .writeRegE(writeRegE), .regWriteE(regWriteE), .memToRegE(memToRegE),
        .writeRegM(writeRegM), .memToRegM(memToRegM), .branchTakenD(branchTakenD),
        .jumpD(jumpD), .stallF(stallF1), .stallD(stallD1), .flushD(flushD1),
        .flushE(flushE1), .mdStart(mdStart1), .mdBusy(mdBusy1), .stallCount(stallCount1));

    int tests = 0;
    int fails = 0;

    // Model: remaining busy cycles and stall tallies per instance.
    int rem0 = 0, rem1 = 0, cnt0 = 0, cnt1 = 0;
    bit es0, es1, est0, est1;
    // Values seen at the most recent sample point.
    bit s_stall0, s_stall1, s_flush0, s_flush1, s_start0, s_start1, s_busy0, s_busy1;
    int s_cnt0, s_cnt1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_in();
        opcodeD = 6'h00; funcD = 6'h00; rsD = '0; rtD = '0;
        writeRegE = '0; writeRegM = '0; regWriteE = 0; memToRegE = 0;
        memToRegM = 0; branchTakenD = 0; jumpD = 0;
    endtask

    // Sample and check one cycle, then advance the model across the rising edge.
    task automatic step(input string tag);
        bit is_br, is_md, is_mf, lu, br, f0;
        #1;
        if (rst) begin rem0 = 0; rem1 = 0; cnt0 = 0; cnt1 = 0; end
        is_br = (opcodeD == 6'h04) || (opcodeD == 6'h05);
        is_md = (opcodeD == 0) && (funcD >= 6'h18) && (funcD <= 6'h1B);
        is_mf = (opcodeD == 0) && ((funcD == 6'h10) || (funcD == 6'h12));
        lu = memToRegE && regWriteE && writeRegE != 0 && (writeRegE == rsD || writeRegE == rtD);
        br = is_br && ((regWriteE && writeRegE != 0 && (writeRegE == rsD || writeRegE == rtD)) ||
                       (memToRegM && writeRegM != 0 && (writeRegM == rsD || writeRegM == rtD)));
        es0  = !rst && (lu || br || (rem0 > 0 && (is_md || is_mf)));
        es1  = !rst && (lu || br || (rem1 > 0 && (is_md || is_mf)));
        est0 = !rst && rem0 == 0 && is_md && !es0;
        est1 = !rst && rem1 == 0 && is_md && !es1;
        f0   = !rst && (branchTakenD || jumpD) && !es0;

        chk({tag, ".stallF0"}, int'(stallF0), int'(es0));
        chk({tag, ".stallD0"}, int'(stallD0), int'(es0));
        chk({tag, ".flushE0"}, int'(flushE0), int'(es0));
        chk({tag, ".flushD0"}, int'(flushD0), int'(f0));
        chk({tag, ".mdStart0"}, int'(mdStart0), int'(est0));
        chk({tag, ".mdBusy0"}, int'(mdBusy0), int'(rem0 > 0));
        chk({tag, ".stallCount0"}, int'(stallCount0), cnt0);
        chk({tag, ".stallF1"}, int'(stallF1), int'(es1));
        chk({tag, ".stallD1"}, int'(stallD1), int'(es1));
        chk({tag, ".flushE1"}, int'(flushE1), int'(es1));
        chk({tag, ".flushD1"}, int'(flushD1), 0);
        chk({tag, ".mdStart1"}, int'(mdStart1), int'(est1));
        chk({tag, ".mdBusy1"}, int'(mdBusy1), int'(rem1 > 0));
        chk({tag, ".stallCount1"}, int'(stallCount1), cnt1);

        s_stall0 = stallF0; s_stall1 = stallF1; s_flush0 = flushD0; s_flush1 = flushD1;
        s_start0 = mdStart0; s_start1 = mdStart1; s_busy0 = mdBusy0; s_busy1 = mdBusy1;
        s_cnt0 = int'(stallCount0); s_cnt1 = int'(stallCount1);

        @(posedge clk);
        if (rst) begin
            rem0 = 0; rem1 = 0; cnt0 = 0; cnt1 = 0;
        end else begin
            if (est0) rem0 = 4; else if (rem0 > 0) rem0--;
            if (est1) rem1 = 1; else if (rem1 > 0) rem1--;
            if (es0 && cnt0 < 65535) cnt0++;
            if (es1 && cnt1 < 15) cnt1++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [5:0] op, fn;
        logic [4:0] rs, rt, wre, wrm;
        logic       rwe, mre, mrm, bt, j;
        logic       e_stall, e_flush0;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int first0, second0, first1, second1, n_stall, n_busy;
        tbl[0]  = '{6'h23, 6'h00, 5'd5, 5'd1, 5'd5, 5'd0, 1, 1, 0, 0, 0, 1, 0};
        tbl[1]  = '{6'h23, 6'h00, 5'd0, 5'd1, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{6'h23, 6'h00, 5'd2, 5'd7, 5'd7, 5'd0, 1, 1, 0, 0, 0, 1, 0};
        tbl[3]  = '{6'h23, 6'h00, 5'd5, 5'd1, 5'd5, 5'd0, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{6'h04, 6'h00, 5'd1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 1, 0, 1, 0};
        tbl[5]  = '{6'h04, 6'h00, 5'd1, 5'd3, 5'd6, 5'd0, 1, 0, 0, 1, 0, 0, 1};
        tbl[6]  = '{6'h05, 6'h00, 5'd9, 5'd2, 5'd0, 5'd9, 0, 0, 1, 1, 0, 1, 0};
        tbl[7]  = '{6'h04, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1, 0, 0, 1};
        tbl[8]  = '{6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 1};
        tbl[9]  = '{6'h00, 6'h20, 5'd4, 5'd1, 5'd4, 5'd0, 1, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{6'h05, 6'h00, 5'd2, 5'd8, 5'd8, 5'd0, 1, 1, 0, 1, 1, 1, 0};

        clear_in();
        rst = 1;
        @(negedge clk);
        step("reset");
        rst = 0;
        step("idle");

        for (int i = 0; i < 11; i++) begin
            opcodeD = tbl[i].op; funcD = tbl[i].fn; rsD = tbl[i].rs; rtD = tbl[i].rt;
            writeRegE = tbl[i].wre; writeRegM = tbl[i].wrm; regWriteE = tbl[i].rwe;
            memToRegE = tbl[i].mre; memToRegM = tbl[i].mrm; branchTakenD = tbl[i].bt;
            jumpD = tbl[i].j;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.stall0", i), int'(s_stall0), int'(tbl[i].e_stall));
            chk($sformatf("tbl%0d.stall1", i), int'(s_stall1), int'(tbl[i].e_stall));
            chk($sformatf("tbl%0d.flush0", i), int'(s_flush0), int'(tbl[i].e_flush0));
            chk($sformatf("tbl%0d.flush1", i), int'(s_flush1), 0);
        end
        clear_in();
        step("drain");

        // MULT then MFLO: stalled for the full MD_LAT=4 occupancy.
        funcD = 6'h18;
        step("mult");
        chk("mult.start0", int'(s_start0), 1);
        funcD = 6'h12;
        n_stall = 0; n_busy = 0;
        for (int k = 0; k < 10; k++) begin
            step("mflo");
            if (s_busy0) n_busy++;
            if (!s_stall0) break;
            n_stall++;
        end
        chk("mflo.stall_cycles", n_stall, 4);
        chk("mult.busy_cycles", n_busy, 4);
        clear_in();

        // Unrelated ALU op proceeds while busy.
        funcD = 6'h19;
        step("multu");
        funcD = 6'h20;
        for (int k = 0; k < 3; k++) begin
            step("add_busy");
            chk("add_busy.nostall", int'(s_stall0), 0);
        end
        clear_in();
        repeat (3) step("drain");

        // Back-to-back DIV, DIVU: issue spacing is MD_LAT+1.
        first0 = -1; second0 = -1; first1 = -1; second1 = -1;
        for (int k = 0; k < 12; k++) begin
            funcD = (k == 0) ? 6'h1A : 6'h1B;
            step("divs");
            if (s_start0) begin if (first0 < 0) first0 = k; else if (second0 < 0) second0 = k; end
            if (s_start1) begin if (first1 < 0) first1 = k; else if (second1 < 0) second1 = k; end
        end
        chk("div.first0", first0, 0);
        chk("div.gap0", second0 - first0, 5);
        chk("div.gap1", second1 - first1, 2);
        clear_in();
        repeat (5) step("drain");

        // Reset in the middle of BUSY abandons the operation.
        funcD = 6'h18;
        step("mult_r");
        clear_in();
        repeat (2) step("busy_r");
        rst = 1;
        step("rst_mid");
        chk("rst_mid.busy0", int'(s_busy0), 0);
        chk("rst_mid.cnt0", s_cnt0, 0);
        chk("rst_mid.stall0", int'(s_stall0), 0);
        rst = 0;
        funcD = 6'h10;
        step("mfhi_after_rst");
        chk("mfhi_after_rst.stall0", int'(s_stall0), 0);
        chk("mfhi_after_rst.start0", int'(s_start0), 0);
        clear_in();

        // Saturation of the 4-bit counter under a held load-use hazard.
        opcodeD = 6'h23; memToRegE = 1; regWriteE = 1; writeRegE = 5'd5; rsD = 5'd5;
        for (int k = 0; k < 20; k++) step("sat");
        chk("sat.cnt1", s_cnt1, 15);
        chk("sat.cnt0", s_cnt0, 19);
        clear_in();
        step("sat_done");
        chk("sat_done.cnt1", s_cnt1, 15);
        chk("sat_done.cnt0", s_cnt0, 20);

        // Jump: squashed only without a delay slot.
        jumpD = 1;
        step("jump");
        chk("jump.flush0", int'(s_flush0), 1);
        chk("jump.flush1", int'(s_flush1), 0);
        clear_in();

        // Randomised traffic over a narrow register range to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            logic [5:0] ops[5];
            logic [5:0] fns[8];
            ops = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h02};
            fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h20, 6'h11};
            opcodeD      = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 2) == 0) opcodeD = 6'h00;
            funcD        = fns[$urandom_range(0, 7)];
            rsD          = 5'($urandom_range(0, 3));
            rtD          = 5'($urandom_range(0, 3));
            writeRegE    = 5'($urandom_range(0, 3));
            writeRegM    = 5'($urandom_range(0, 3));
            regWriteE    = 1'($urandom_range(0, 1));
            memToRegE    = ($urandom_range(0, 3) == 0);
            memToRegM    = ($urandom_range(0, 3) == 0);
            branchTakenD = 1'($urandom_range(0, 1));
            jumpD        = ($urandom_range(0, 5) == 0);
            rst          = ($urandom_range(0, 39) == 0);
            step("rand");
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
